// File: rtl/encoder_spi_pkg.sv
// -----------------------------------------------------------------------------
// encoder_spi_pkg
// Shared definitions for the multi-channel absolute-encoder SPI poller:
//   - state_e      : poller FSM states (IDLE, SETUP, SHIFT, GAP)
//   - FRAME_CNT_W  : width of the completed-frame counter
//   - frame_parity : XOR parity of a frame (zero-extended to 32 bits)
// Optional feature macro used by the poller: ENC_SPI_PARITY_EN
// -----------------------------------------------------------------------------
package encoder_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int FRAME_CNT_W  = 16;

    // Widest frame the poller supports; narrower frames are zero-extended,
    // which leaves the XOR parity unchanged.
    localparam int PARITY_MAX_W = 32;

    // Returns 1 when the frame holds an odd number of ones. A frame whose
    // bit 0 is a correct even-parity bit therefore returns 0.
    function automatic logic frame_parity(input logic [PARITY_MAX_W-1:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/encoder_spi_shift.sv
// -----------------------------------------------------------------------------
// encoder_spi_shift
// Per-channel receive slice of the encoder poller: serial shift register,
// raw-frame and position capture registers, and the optional parity flag.
// Configuration: ENC_SPI_PARITY_EN enables the parity flag (otherwise 0).
// Ports:
//   sck        in   block clock
//   rst_n      in   asynchronous active-low reset
//   miso       in   serial data from this channel's encoder
//   shift_en   in   shift miso into the shift register this cycle
//   capture    in   last bit of the frame: load frame/pos/parity this cycle
//   frame_val  out  last complete raw frame (FRAME_W bits)
//   pos_val    out  frame_val[POS_LSB +: POS_W]
//   parity_err out  odd parity of the last frame (parity build only)
// -----------------------------------------------------------------------------
module encoder_spi_shift
    import encoder_spi_pkg::*;
#(
    parameter int FRAME_W = 24,
    parameter int POS_LSB = 3,
    parameter int POS_W   = 19
) (
    input  logic               sck,
    input  logic               rst_n,
    input  logic               miso,
    input  logic               shift_en,
    input  logic               capture,
    output logic [FRAME_W-1:0] frame_val,
    output logic [POS_W-1:0]   pos_val,
    output logic               parity_err
);

    // Only FRAME_W-1 bits need storing: the final bit is taken straight from
    // miso on the capture cycle.
    logic [FRAME_W-2:0] shreg_r;
    logic [FRAME_W-1:0] frame_s;
    logic [FRAME_W-1:0] frame_r;
    logic [POS_W-1:0]   pos_r;

    // First bit received ends up as the MSB of the frame.
    assign frame_s = {shreg_r, miso};

    // Serial shift register, filled from the LSB end.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= '0;
        end else if (shift_en) begin
            shreg_r <= frame_s[FRAME_W-2:0];
        end else begin
            shreg_r <= shreg_r;
        end
    end

    // Capture registers: change only on the capture cycle, so they never
    // move without the shared data_valid pulse.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            frame_r <= '0;
            pos_r   <= '0;
        end else if (capture) begin
            frame_r <= frame_s;
            pos_r   <= frame_s[POS_LSB +: POS_W];
        end else begin
            frame_r <= frame_r;
            pos_r   <= pos_r;
        end
    end

`ifdef ENC_SPI_PARITY_EN
    // Parity flag, updated together with the frame; POS_LSB must be >= 1 so
    // the parity bit is not part of the position field.
    logic parity_r;

    // Parity flag register.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else if (capture) begin
            parity_r <= frame_parity(PARITY_MAX_W'(frame_s));
        end else begin
            parity_r <= parity_r;
        end
    end

    assign parity_err = parity_r;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_val = frame_r;
    assign pos_val   = pos_r;

endmodule

// File: rtl/encoder_spi_poller.sv
// -----------------------------------------------------------------------------
// encoder_spi_poller
// Free-running SPI reader for NUM_CH absolute rotary encoders sharing one SCK.
// Each frame: one SETUP cycle (cs_n low, encoder output setup), FRAME_W SHIFT
// cycles sampling miso MSB first, then GAP_CYCLES cycles with cs_n high.
// Configuration: define ENC_SPI_PARITY_EN to treat frame bit 0 as an
// even-parity bit and report per-channel parity_err; otherwise parity_err=0.
// Ports:
//   sck        in   block clock, also forwarded to the encoders
//   rst_n      in   asynchronous active-low reset
//   enable     in   start/continue polling (sampled in IDLE and at GAP end)
//   miso       in   per-channel serial data (bit i = channel i)
//   cs_n       out  per-channel chip selects, all driven identically
//   frame_val  out  last raw frame per channel, channel i at [i*FRAME_W +: FRAME_W]
//   pos_val    out  position field per channel, channel i at [i*POS_W +: POS_W]
//   data_valid out  one-cycle pulse when frame_val/pos_val update
//   busy       out  high in every state except IDLE
//   frame_cnt  out  completed-frame count, wraps 0xFFFF -> 0
//   parity_err out  per-channel parity error of the last frame
// -----------------------------------------------------------------------------
module encoder_spi_poller
    import encoder_spi_pkg::*;
#(
    parameter int NUM_CH     = 1,
    parameter int FRAME_W    = 24,
    parameter int POS_LSB    = 3,
    parameter int POS_W      = 19,
    parameter int GAP_CYCLES = 16
) (
    input  logic                      sck,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         miso,
    output logic [NUM_CH-1:0]         cs_n,
    output logic [NUM_CH*FRAME_W-1:0] frame_val,
    output logic [NUM_CH*POS_W-1:0]   pos_val,
    output logic                      data_valid,
    output logic                      busy,
    output logic [FRAME_CNT_W-1:0]    frame_cnt,
    output logic [NUM_CH-1:0]         parity_err
);

    localparam int BIT_W = $clog2(FRAME_W);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    // Terminal counts: both counters stop at these values, so neither wraps
    // inside its state.
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_e                 state_r;
    state_e                 next_state_s;
    logic                   shift_en_s;
    logic                   capture_s;
    logic                   cs_low_s;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic [GAP_W-1:0]       gap_cnt_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic [NUM_CH-1:0]      cs_n_r;
    logic                   data_valid_r;
    logic                   busy_r;

    // FSM state register.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and per-cycle control strobes.
    always_comb begin
        next_state_s = state_r;
        shift_en_s   = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    next_state_s = SETUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                next_state_s = SHIFT;
            end
            SHIFT: begin
                shift_en_s = 1'b1;
                if (bit_cnt_r == BIT_LAST) begin
                    capture_s    = 1'b1;
                    next_state_s = GAP;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    if (enable) begin
                        next_state_s = SETUP;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = GAP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        // Chip select is asserted for exactly the SETUP and SHIFT states.
        cs_low_s = (next_state_s == SETUP) || (next_state_s == SHIFT);
    end

    // Bit counter: cleared in SETUP, advances through SHIFT, stops at the last bit.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= '0;
        end else if (state_r == SETUP) begin
            bit_cnt_r <= '0;
        end else if (shift_en_s && !capture_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Gap counter: cleared when the frame completes, stops at its terminal count.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_r <= '0;
        end else if (capture_s) begin
            gap_cnt_r <= '0;
        end else if ((state_r == GAP) && (gap_cnt_r != GAP_LAST)) begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    // Registered outputs: chip selects, busy, data_valid pulse and frame counter.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_r       <= {NUM_CH{1'b1}};
            busy_r       <= 1'b0;
            data_valid_r <= 1'b0;
            frame_cnt_r  <= '0;
        end else begin
            cs_n_r       <= cs_low_s ? {NUM_CH{1'b0}} : {NUM_CH{1'b1}};
            busy_r       <= (next_state_s != IDLE);
            data_valid_r <= capture_s;
            if (capture_s) begin
                frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // One receive slice per encoder channel, all driven by the shared strobes.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        encoder_spi_shift #(
            .FRAME_W (FRAME_W),
            .POS_LSB (POS_LSB),
            .POS_W   (POS_W)
        ) u_shift (
            .sck        (sck),
            .rst_n      (rst_n),
            .miso       (miso[ch]),
            .shift_en   (shift_en_s),
            .capture    (capture_s),
            .frame_val  (frame_val[ch*FRAME_W +: FRAME_W]),
            .pos_val    (pos_val[ch*POS_W +: POS_W]),
            .parity_err (parity_err[ch])
        );
    end

    assign cs_n       = cs_n_r;
    assign busy       = busy_r;
    assign data_valid = data_valid_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_encoder_spi_poller.sv
// -----------------------------------------------------------------------------
// tb_encoder_spi_poller
// Self-checking bench for encoder_spi_poller (2 channels, default framing).
// An encoder model answers every cs_n-low window with a fresh word, pushing
// the expected capture into a scoreboard; a monitor pops and compares on each
// data_valid and checks hold values, latency and cs_n timing in between.
// -----------------------------------------------------------------------------
module tb_encoder_spi_poller;

    localparam int NUM_CH     = 2;
    localparam int FRAME_W    = 24;
    localparam int POS_LSB    = 3;
    localparam int POS_W      = 19;
    localparam int GAP_CYCLES = 16;
    localparam int NF         = NUM_CH * FRAME_W;
    localparam int NP         = NUM_CH * POS_W;
    localparam int PERIOD     = 1 + FRAME_W + GAP_CYCLES;

    logic              sck    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              enable = 1'b0;
    logic [NUM_CH-1:0] miso   = '0;
    logic [NUM_CH-1:0] cs_n;
    logic [NF-1:0]     frame_val;
    logic [NP-1:0]     pos_val;
    logic              data_valid;
    logic              busy;
    logic [15:0]       frame_cnt;
    logic [NUM_CH-1:0] parity_err;

    encoder_spi_poller #(
        .NUM_CH     (NUM_CH),
        .FRAME_W    (FRAME_W),
        .POS_LSB    (POS_LSB),
        .POS_W      (POS_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .sck        (sck),
        .rst_n      (rst_n),
        .enable     (enable),
        .miso       (miso),
        .cs_n       (cs_n),
        .frame_val  (frame_val),
        .pos_val    (pos_val),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .parity_err (parity_err)
    );

    always #5 sck = ~sck;

    typedef struct {
        logic [NF-1:0]     frame;
        logic [NP-1:0]     pos;
        logic [15:0]       cnt;
        logic [NUM_CH-1:0] perr;
    } exp_t;

    exp_t          exp_q[$];
    logic [NF-1:0] dir_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0]       model_cnt  = 16'd0;
    logic [NF-1:0]     hold_frame = '0;
    logic [NP-1:0]     hold_pos   = '0;
    logic [15:0]       hold_cnt   = 16'd0;
    logic [NUM_CH-1:0] hold_perr  = '0;

    // Timing observations
    int cyc           = 0;
    int last_fall     = 0;
    int last_rise     = 0;
    int busy_fall_cyc = 0;
    int fall_count    = 0;
    int run_falls     = 0;
    bit chk_period    = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected result of one frame, from the word each encoder transmits.
    function automatic void push_expected(input logic [NF-1:0] w);
        exp_t             e;
        logic [FRAME_W-1:0] chw;
        model_cnt = model_cnt + 16'd1;
        e.frame   = w;
        e.cnt     = model_cnt;
        e.pos     = '0;
        e.perr    = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            chw = w[ch*FRAME_W +: FRAME_W];
            e.pos[ch*POS_W +: POS_W] = POS_W'(chw >> POS_LSB);
`ifdef ENC_SPI_PARITY_EN
            e.perr[ch] = ^chw;
`else
            e.perr[ch] = 1'b0;
`endif
        end
        exp_q.push_back(e);
    endfunction

    always @(posedge sck) cyc++;

    // Encoder model: while cs_n is low, the first falling SCK edge is the
    // setup slot; the next FRAME_W falling edges present the word MSB first.
    initial begin : encoder_model
        int            k;
        logic [NF-1:0] cur_word;
        k = 0;
        cur_word = '0;
        forever begin
            @(negedge sck);
            if (cs_n[0]) begin
                k = 0;
                miso = NUM_CH'($urandom);
            end else begin
                if (k == 0) begin
                    if (dir_q.size() > 0) begin
                        cur_word = dir_q.pop_front();
                    end else begin
                        for (int ch = 0; ch < NUM_CH; ch++)
                            cur_word[ch*FRAME_W +: FRAME_W] = FRAME_W'($urandom);
                    end
                    push_expected(cur_word);
                    miso = NUM_CH'($urandom);
                end else if (k <= FRAME_W) begin
                    for (int ch = 0; ch < NUM_CH; ch++)
                        miso[ch] = cur_word[ch*FRAME_W + FRAME_W - k];
                end else begin
                    miso = NUM_CH'($urandom);
                end
                k++;
            end
        end
    end

    // Monitor: scoreboard compare on data_valid, hold checks otherwise,
    // plus chip-select timing.
    initial begin : monitor
        logic prev_cs;
        logic prev_busy;
        exp_t e;
        prev_cs   = 1'b1;
        prev_busy = 1'b0;
        forever begin
            @(negedge sck);
            if (prev_cs && !cs_n[0]) begin
                if (chk_period && run_falls > 0) begin
                    check("frame_period", 64'(cyc - last_fall), 64'(PERIOD));
                    check("cs_high_len", 64'(cyc - last_rise), 64'(GAP_CYCLES));
                end
                if (chk_period) run_falls++;
                last_fall = cyc;
                fall_count++;
            end
            if (!prev_cs && cs_n[0]) begin
                if (rst_n) check("cs_low_len", 64'(cyc - last_fall), 64'(FRAME_W + 1));
                last_rise = cyc;
            end
            prev_cs = cs_n[0];
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            prev_busy = busy;

            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_data_valid", 64'(data_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("frame_val", 64'(frame_val), 64'(e.frame));
                    check("pos_val", 64'(pos_val), 64'(e.pos));
                    check("frame_cnt", 64'(frame_cnt), 64'(e.cnt));
                    check("parity_err", 64'(parity_err), 64'(e.perr));
                    check("dv_latency", 64'(cyc - last_fall), 64'(FRAME_W + 1));
                    hold_frame = e.frame;
                    hold_pos   = e.pos;
                    hold_cnt   = e.cnt;
                    hold_perr  = e.perr;
                end
            end else begin
                check("frame_hold", 64'(frame_val), 64'(hold_frame));
                check("pos_hold", 64'(pos_val), 64'(hold_pos));
                check("cnt_hold", 64'(frame_cnt), 64'(hold_cnt));
                check("perr_hold", 64'(parity_err), 64'(hold_perr));
            end
        end
    end

    task automatic wait_cs_low(input int budget);
        int n;
        n = 0;
        while (cs_n[0] !== 1'b0 && n < budget) begin
            @(negedge sck);
            n++;
        end
        check("cs_fall_timeout", 64'(cs_n[0]), 64'(0));
    endtask

    task automatic wait_dv(input int budget);
        int n;
        n = 0;
        while (data_valid !== 1'b1 && n < budget) begin
            @(negedge sck);
            n++;
        end
        check("data_valid_timeout", 64'(data_valid), 64'(1));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge sck);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cs_n"}, 64'(cs_n), 64'({NUM_CH{1'b1}}));
        check({tag, "_frame_val"}, 64'(frame_val), 64'(0));
        check({tag, "_pos_val"}, 64'(pos_val), 64'(0));
        check({tag, "_data_valid"}, 64'(data_valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
        check({tag, "_parity_err"}, 64'(parity_err), 64'(0));
    endtask

    initial begin : stimulus
        int snap;
        // Reset state
        repeat (3) @(negedge sck);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge sck);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_cs_n", 64'(cs_n), 64'({NUM_CH{1'b1}}));

        // Continuous polling with directed words first (ch1 in upper half)
        dir_q.push_back({24'h000001, 24'hFFFFFE});
        dir_q.push_back({24'h5A5A5A, 24'h5A5A5A});
        dir_q.push_back({24'h5A5A5B, 24'h5A5A5B});
        dir_q.push_back({24'h5A5A5A, 24'h5A5A5A});
        run_falls  = 0;
        chk_period = 1'b1;
        enable     = 1'b1;
        repeat (6 * PERIOD) @(negedge sck);
        chk_period = 1'b0;
        enable     = 1'b0;
        wait_idle(3 * PERIOD);
        check("run_frames_ge5", 64'(run_falls >= 5), 64'(1));

        // Enable dropped 5 cycles into SHIFT: frame completes, then IDLE
        repeat (2) @(negedge sck);
        enable = 1'b1;
        wait_cs_low(20);
        repeat (6) @(negedge sck);
        enable = 1'b0;
        wait_dv(2 * FRAME_W);
        wait_idle(2 * PERIOD);
        @(negedge sck);
        check("busy_fall_after_gap", 64'(busy_fall_cyc - last_rise), 64'(GAP_CYCLES));
        snap = fall_count;
        repeat (60) @(negedge sck);
        check("no_restart_falls", 64'(fall_count), 64'(snap));
        check("no_restart_busy", 64'(busy), 64'(0));
        check("no_restart_cs_n", 64'(cs_n), 64'({NUM_CH{1'b1}}));

        // Reset asserted at bit 10 of a frame
        enable = 1'b1;
        wait_cs_low(20);
        repeat (11) @(negedge sck);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_cnt  = 16'd0;
        hold_frame = '0;
        hold_pos   = '0;
        hold_cnt   = 16'd0;
        hold_perr  = '0;
        #1;
        check_reset_values("midreset");
        repeat (3) @(negedge sck);
        rst_n = 1'b1;
        wait_dv(3 * PERIOD);
        @(negedge sck);
        check("cnt_after_reset", 64'(frame_cnt), 64'(1));
        enable = 1'b0;
        wait_idle(3 * PERIOD);

        // Random enable toggling with random words
        repeat (1500) begin
            @(negedge sck);
            if ($urandom_range(0, 29) == 0) enable = ~enable;
        end
        enable = 1'b0;
        wait_idle(3 * PERIOD);
        repeat (3) @(negedge sck);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_spi_poller.md
# encoder_spi_poller

Parametrised, free-running SPI reader for absolute rotary encoders. It polls NUM_CH encoders in parallel: all channels share one SCK, each has its own chip-select and MISO line. Each frame is FRAME_W bits long, and a POS_W-bit position field is extracted from it. It supersedes the single-channel, fixed-24-bit encoder reader and adds these features:
- chip-select generation,
- an inter-frame gap,
- a frame counter,
- an optional parity check.

Results feed the MicroBlaze register interface.

## Interface
Parameters:
- NUM_CH, 1: number of encoder channels, 1..8
- FRAME_W, 24: bits per SPI frame, MSB first, 8..32
- POS_LSB, 3: frame bit index of the position field LSB
- POS_W, 19: position field width; POS_LSB+POS_W <= FRAME_W
- GAP_CYCLES, 16: SCK cycles with cs_n high between frames, >= 1

Ports:
- sck  in  1  block clock, also forwarded to the encoders; max 5 MHz
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  start/continue polling while high
- miso  in  NUM_CH  serial data, bit i from channel i
- cs_n  out  NUM_CH  active-low chip selects, all driven identically
- frame_val  out  NUM_CH*FRAME_W  last complete raw frame per channel; channel i at [i*FRAME_W +: FRAME_W]
- pos_val  out  NUM_CH*POS_W  frame[POS_LSB +: POS_W] per channel
- data_valid  out  1  one-cycle pulse when frame_val/pos_val update
- busy  out  1  high in every state except IDLE
- frame_cnt  out  16  count of completed frames, wraps 0xFFFF -> 0
- parity_err  out  NUM_CH  per-channel parity error of the last frame (see Configuration)

## Operation
- The FSM has four states: IDLE, SETUP, SHIFT, GAP. All registers update on posedge sck.
- IDLE: cs_n all 1. If enable=1, go to SETUP and drive cs_n to 0.
- SETUP: lasts one cycle, giving the encoder its output setup time. Clear bit_cnt, then go to SHIFT.
- SHIFT: each cycle, shift miso[i] into shreg[i] from the LSB end, so the first bit received ends up as the MSB. bit_cnt increments each cycle.
- Leaving SHIFT: on the cycle bit_cnt = FRAME_W-1, sample the last bit and do all of the following:
  - load frame_val[i] = {shreg[i][FRAME_W-2:0], miso[i]}
  - load pos_val from that frame
  - data_valid <= 1
  - frame_cnt <= frame_cnt+1
  - cs_n <= all 1
  - go to GAP and clear gap_cnt
- GAP: hold for GAP_CYCLES cycles. Then go to SETUP (with cs_n <= 0) if enable=1, otherwise go to IDLE.
- enable is only sampled in IDLE and at the end of GAP. Deasserting it mid-frame never aborts the frame; the frame completes normally.
- frame_val and pos_val hold their values between updates. They never change without a data_valid pulse.
- Reset values: cs_n all 1, frame_val 0, pos_val 0, data_valid 0, busy 0, frame_cnt 0, parity_err 0, state IDLE.
- Reset mid-frame: cs_n rises asynchronously and the partial frame is discarded. The outputs keep their reset values until the first complete frame after reset.
- Counter widths: bit_cnt is $clog2(FRAME_W) bits; gap_cnt is $clog2(GAP_CYCLES+1) bits. Neither counter may wrap inside a state.

## Timing
- Let edge E0 be the edge where IDLE sees enable=1. cs_n falls after E0, and E1 is SETUP.
- Bits are sampled at E2..E(FRAME_W+1). Outputs and data_valid are visible after E(FRAME_W+1); cs_n rises at that same edge.
- Latency from cs_n falling to data_valid rising is FRAME_W+1 cycles.
- Steady-state frame period is 1+FRAME_W+GAP_CYCLES cycles. With the defaults this is 41 cycles.
- data_valid is exactly one cycle wide. busy falls at the edge where GAP exits to IDLE.

## Configuration
- ENC_SPI_PARITY_EN defined:
  - frame bit 0 is an even-parity bit over frame[FRAME_W-1:1].
  - parity_err[i] is set to (^frame[i]) in the same edge as data_valid, and is held until the next frame.
  - POS_LSB must be >= 1.
- ENC_SPI_PARITY_EN undefined:
  - parity_err is tied to 0.
  - frame bit 0 is treated as ordinary data.

## Structure
- Package encoder_spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, GAP),
  - a localparam for the frame_cnt width (16),
  - a function that returns the parity of a frame.
- Sub-module encoder_spi_shift, generated NUM_CH times, contains per-channel shreg, the frame/pos capture registers, and the parity flag.
- The top level holds the shared FSM, bit_cnt, gap_cnt, frame_cnt and cs_n.

## Test plan
- Defaults, NUM_CH=1, miso drives 0x5A5A5A MSB first -> frame_val=0x5A5A5A, pos_val=0x34B4B, data_valid pulses once 25 cycles after cs_n falls, frame_cnt=1.
- NUM_CH=2, channel 0 sends 0xFFFFFE and channel 1 sends 0x000001 -> frame_val=0x000001_FFFFFE (channel 1 in the upper 24 bits), single shared data_valid pulse.
- enable held high -> cs_n low for 25 cycles then high for exactly 16, repeating; period 41 cycles; frame_cnt increments every period.
- enable dropped 5 cycles into SHIFT -> frame still completes, data_valid pulses, FSM returns to IDLE after GAP, busy=0, no new cs_n fall.
- rst_n asserted at bit 10 of a frame -> cs_n=1 immediately, all outputs 0; after release with enable=1, the next full frame is captured correctly.
- With ENC_SPI_PARITY_EN, frame 0x5A5A5B (odd popcount) -> parity_err=1; the following frame 0x5A5A5A -> parity_err=0.
